// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hazard_sequencer
// Brief    : Pipeline sequencer for the 5-stage CPU: stall/flush/boot/drain.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_sequencer #(
    parameter int BOOT_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             startin,
    input  logic             halt_req,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rt,
    input  logic             EX_mem_read,
    input  logic [4:0]       EX_rt,
    input  logic             MEM_br_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int BOOT_W  = $clog2(BOOT_CYCLES + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BOOT_W-1:0]  boot_cnt_q, boot_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;
    logic [CNT_W-1:0]   flush_count_q, flush_count_d;
    logic               halted_q, halted_d;
    logic               w_lu, w_br, w_stall_inc, w_flush_inc;

    // A load into r0 never creates a real dependency.
    assign w_lu = EX_mem_read && (EX_rt != 5'd0) &&
                  ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
    assign w_br = MEM_br_taken;

    always_comb begin
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;

        case (state_q)
            ST_BOOT: begin
                boot_cnt_d = boot_cnt_q + BOOT_W'(1);
                if (boot_cnt_q == BOOT_W'(BOOT_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_id_flush  = 1'b0;
                id_ex_flush  = 1'b0;
                ex_mem_flush = 1'b0;
                if (w_br) begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    w_flush_inc  = 1'b1;
                end else if (w_lu) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    w_stall_inc = 1'b1;
                end
                if (halt_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if_id_write  = 1'b1;
                id_ex_flush  = 1'b0;
                ex_mem_flush = 1'b0;
                if (w_br) begin
                    // Redirect PC now so a later resume starts at the branch target.
                    pc_write     = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    w_flush_inc  = 1'b1;
                end else if (w_lu) begin
                    if_id_write = 1'b0;
                    if_id_flush = 1'b0;
                    id_ex_flush = 1'b1;
                    w_stall_inc = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                    if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        state_d = ST_HALTED;
                    end
                end
                if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        stall_count_d = (w_stall_inc && (stall_count_q != {CNT_W{1'b1}}))
                        ? stall_count_q + CNT_W'(1) : stall_count_q;
        flush_count_d = (w_flush_inc && (flush_count_q != {CNT_W{1'b1}}))
                        ? flush_count_q + CNT_W'(1) : flush_count_q;
        halted_d      = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            state_q       <= ST_BOOT;
            boot_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
            halted_q      <= halted_d;
        end
    end

    assign halted      = halted_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_sequencer
// Brief    : Directed self-checking bench for hazard_sequencer (CNT_W=4 build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             startin;
    logic             halt_req;
    logic [4:0]       ID_rs, ID_rt, EX_rt;
    logic             ID_uses_rt, EX_mem_read, MEM_br_taken;
    logic             pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_count, flush_count;

    int errors = 0;
    int checks = 0;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush}
    localparam logic [4:0] C_BOOT  = 5'b00111;
    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_BR    = 5'b11111;
    localparam logic [4:0] C_DRAIN = 5'b01100;
    localparam logic [4:0] C_DSTL  = 5'b00010;

    wire [4:0] ctrl = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush};

    always #5 clk = ~clk;

    hazard_sequencer #(.BOOT_CYCLES(2), .DRAIN_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .startin(startin), .halt_req(halt_req),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
        .EX_mem_read(EX_mem_read), .EX_rt(EX_rt), .MEM_br_taken(MEM_br_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .halted(halted),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic idle_inputs();
        ID_rs = 5'd1; ID_rt = 5'd2; ID_uses_rt = 1'b0;
        EX_mem_read = 1'b0; EX_rt = 5'd0; MEM_br_taken = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        startin = 1'b0; halt_req = 1'b0; idle_inputs();
        repeat (3) next_cycle();
        #1;
        checks++; if (ctrl !== C_BOOT) begin errors++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_BOOT); end
        checks++; if (stall_count !== 4'd0 || flush_count !== 4'd0 || halted !== 1'b0) begin
            errors++; $display("FAIL reset_regs got=%0d/%0d/%b exp=0/0/0", stall_count, flush_count, halted); end
        startin = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (ctrl !== C_BOOT) begin errors++; $display("FAIL boot_cycle%0d got=%b exp=%b", i, ctrl, C_BOOT); end
            next_cycle();
        end
        #1;
        checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL boot_to_run got=%b exp=%b", ctrl, C_RUN); end
        checks++; if (stall_count !== 4'd0 || flush_count !== 4'd0) begin
            errors++; $display("FAIL boot_counters got=%0d/%0d exp=0/0", stall_count, flush_count); end
    endtask

    task automatic test_load_use();
        next_cycle();
        EX_mem_read = 1'b1; EX_rt = 5'd8; ID_rs = 5'd8; #1;
        checks++; if (ctrl !== C_STALL) begin errors++; $display("FAIL lu_rs got=%b exp=%b", ctrl, C_STALL); end
        next_cycle();
        checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_rs_count got=%0d exp=1", stall_count); end
        EX_rt = 5'd0; ID_rs = 5'd0; #1;
        checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL lu_r0 got=%b exp=%b", ctrl, C_RUN); end
        next_cycle();
        checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_r0_count got=%0d exp=1", stall_count); end
        EX_rt = 5'd9; ID_rs = 5'd3; ID_rt = 5'd9; ID_uses_rt = 1'b0; #1;
        checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL lu_rt_unused got=%b exp=%b", ctrl, C_RUN); end
        next_cycle();
        ID_uses_rt = 1'b1; #1;
        checks++; if (ctrl !== C_STALL) begin errors++; $display("FAIL lu_rt got=%b exp=%b", ctrl, C_STALL); end
        next_cycle();
        checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL lu_rt_count got=%0d exp=2", stall_count); end
        idle_inputs();
    endtask

    task automatic test_branch();
        EX_mem_read = 1'b1; EX_rt = 5'd8; ID_rs = 5'd8; MEM_br_taken = 1'b1; #1;
        checks++; if (ctrl !== C_BR) begin errors++; $display("FAIL br_over_lu got=%b exp=%b", ctrl, C_BR); end
        next_cycle();
        checks++; if (flush_count !== 4'd1 || stall_count !== 4'd2) begin
            errors++; $display("FAIL br_counts got=%0d/%0d exp=1/2", flush_count, stall_count); end
        idle_inputs();
    endtask

    task automatic test_drain();
        halt_req = 1'b1; #1;
        checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL halt_entry got=%b exp=%b", ctrl, C_RUN); end
        for (int i = 0; i < 4; i++) begin
            next_cycle(); #1;
            checks++; if (ctrl !== C_DRAIN || halted !== 1'b0) begin
                errors++; $display("FAIL drain%0d got=%b/%b exp=%b/0", i, ctrl, halted, C_DRAIN); end
        end
        next_cycle(); #1;
        checks++; if (ctrl !== C_BOOT || halted !== 1'b1) begin
            errors++; $display("FAIL halted got=%b/%b exp=%b/1", ctrl, halted, C_BOOT); end
        halt_req = 1'b0; #1;
        checks++; if (ctrl !== C_BOOT || halted !== 1'b1) begin
            errors++; $display("FAIL halted_release got=%b/%b exp=%b/1", ctrl, halted, C_BOOT); end
        next_cycle(); #1;
        checks++; if (ctrl !== C_RUN || halted !== 1'b0) begin
            errors++; $display("FAIL resume got=%b/%b exp=%b/0", ctrl, halted, C_RUN); end
    endtask

    task automatic test_drain_hazards();
        next_cycle();
        halt_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if (i == 1) begin EX_mem_read = 1'b1; EX_rt = 5'd4; ID_rs = 5'd4; end
            else idle_inputs();
            #1;
            checks++; if (ctrl !== ((i == 1) ? C_DSTL : C_DRAIN) || halted !== 1'b0) begin
                errors++; $display("FAIL drain_lu%0d got=%b/%b exp=%b/0", i, ctrl, halted, (i == 1) ? C_DSTL : C_DRAIN); end
        end
        next_cycle(); idle_inputs(); #1;
        checks++; if (halted !== 1'b1 || stall_count !== 4'd3) begin
            errors++; $display("FAIL drain_lu_end got=%b/%0d exp=1/3", halted, stall_count); end
        halt_req = 1'b0;
        next_cycle();
        halt_req = 1'b1;
        next_cycle();
        MEM_br_taken = 1'b1; #1;
        checks++; if (ctrl !== C_BR) begin errors++; $display("FAIL drain_br got=%b exp=%b", ctrl, C_BR); end
        next_cycle();
        MEM_br_taken = 1'b0; halt_req = 1'b0; #1;
        checks++; if (ctrl !== C_DRAIN || flush_count !== 4'd2) begin
            errors++; $display("FAIL drain_after_br got=%b/%0d exp=%b/2", ctrl, flush_count, C_DRAIN); end
        next_cycle(); #1;
        checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL drain_abort got=%b exp=%b", ctrl, C_RUN); end
    endtask

    task automatic test_saturate_and_async_reset();
        EX_mem_read = 1'b1; EX_rt = 5'd7; ID_rs = 5'd7;
        repeat (20) next_cycle();
        idle_inputs(); #1;
        checks++; if (stall_count !== 4'd15 || flush_count !== 4'd2) begin
            errors++; $display("FAIL saturate got=%0d/%0d exp=15/2", stall_count, flush_count); end
        halt_req = 1'b1;
        next_cycle(); next_cycle(); #1;
        checks++; if (ctrl !== C_DRAIN) begin errors++; $display("FAIL pre_reset_drain got=%b exp=%b", ctrl, C_DRAIN); end
        #1 startin = 1'b0; #1;
        checks++; if (ctrl !== C_BOOT || stall_count !== 4'd0 || flush_count !== 4'd0 || halted !== 1'b0) begin
            errors++; $display("FAIL async_reset got=%b/%0d/%0d/%b exp=%b/0/0/0", ctrl, stall_count, flush_count, halted, C_BOOT); end
        halt_req = 1'b0;
        next_cycle(); startin = 1'b1;
        next_cycle(); #1;
        checks++; if (ctrl !== C_BOOT) begin errors++; $display("FAIL reboot got=%b exp=%b", ctrl, C_BOOT); end
        next_cycle(); #1;
        checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL reboot_run got=%b exp=%b", ctrl, C_RUN); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_drain();
        test_drain_hazards();
        test_saturate_and_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
